// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter that shares one two-stage multiplier
// pipeline (operand register S1, output register S2) between NUM_REQ
// requesters. Each response carries the ID of the requester that issued it.

// op_mult: combinational N x N -> 2N multiplier with overflow detection and
// optional saturation. The product is formed one bit wider than the result so
// that ov reflects whether the true product fits in 2N bits.
module op_mult #(
    parameter int N        = 8,
    parameter bit SIGNED   = 1'b0,
    parameter bit SATURATE = 1'b0
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] result_o,
    output logic           ov_o
);

    logic [2*N:0] a_x;
    logic [2*N:0] b_x;
    logic [2*N:0] prod_x;

    // Extend operands to 2N+1 bits and multiply; the low 2N+1 bits of the
    // product are exact for both interpretations.
    always_comb begin
        a_x    = SIGNED ? {{(N+1){a_i[N-1]}}, a_i} : {{(N+1){1'b0}}, a_i};
        b_x    = SIGNED ? {{(N+1){b_i[N-1]}}, b_i} : {{(N+1){1'b0}}, b_i};
        prod_x = a_x * b_x;
    end

    // Flag results that do not fit in 2N bits and clamp them when saturating.
    always_comb begin
        ov_o     = SIGNED ? (prod_x[2*N] ^ prod_x[2*N-1]) : prod_x[2*N];
        result_o = prod_x[2*N-1:0];
        if (ov_o && SATURATE) begin
            if (!SIGNED)
                result_o = {(2*N){1'b1}};
            else if (prod_x[2*N])
                result_o = {1'b1, {(2*N-1){1'b0}}};
            else
                result_o = {1'b0, {(2*N-1){1'b1}}};
        end
    end

endmodule

module mult_arbiter #(
    parameter int N        = 8,
    parameter int NUM_REQ  = 4,
    parameter bit SATURATE = 1'b0,
    parameter int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_signed,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [2*N-1:0]       rsp_result,
    output logic                 rsp_ov
);

    // Round-robin pointer: last granted requester.
    logic [IDW-1:0] last_q, last_d;

    // S1: operand register.
    logic           s1_valid_q, s1_valid_d;
    logic [N-1:0]   s1_a_q, s1_a_d;
    logic [N-1:0]   s1_b_q, s1_b_d;
    logic           s1_signed_q, s1_signed_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;

    // S2: output register.
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [2*N-1:0] rsp_result_q, rsp_result_d;
    logic           rsp_ov_q, rsp_ov_d;

    logic           s2_free;
    logic           s1_free;
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic           accept;

    logic [2*N-1:0] prod_u, prod_s;
    logic           ov_u, ov_s;

    op_mult #(.N(N), .SIGNED(1'b0), .SATURATE(SATURATE)) u_mult_u (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .result_o (prod_u),
        .ov_o     (ov_u)
    );

    op_mult #(.N(N), .SIGNED(1'b1), .SATURATE(SATURATE)) u_mult_s (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .result_o (prod_s),
        .ov_o     (ov_s)
    );

    assign s2_free = !rsp_valid_q || rsp_ready;
    assign s1_free = !s1_valid_q || s2_free;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        logic [IDW-1:0] cand;
        // NOTE: every combinational output gets a default before any branch;
        // otherwise a path that skips the assignment infers a latch.
        cand        = '0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
        accept    = rst_n && s1_free && grant_found;
        req_ready = '0;
        if (accept)
            req_ready[grant_id] = 1'b1;
    end

    // Next state for the pointer and both pipeline stages.
    always_comb begin
        last_d       = last_q;
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_signed_d  = s1_signed_q;
        s1_id_d      = s1_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_ov_d     = rsp_ov_q;

        if (accept) begin
            s1_valid_d  = 1'b1;
            s1_a_d      = req_a[grant_id*N +: N];
            s1_b_d      = req_b[grant_id*N +: N];
            s1_signed_d = req_signed[grant_id];
            s1_id_d     = grant_id;
            last_d      = grant_id;
        end else if (s2_free) begin
            s1_valid_d = 1'b0;
        end

        if (s2_free) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_id_d     = s1_id_q;
                rsp_result_d = s1_signed_q ? prod_s : prod_u;
                rsp_ov_d     = s1_signed_q ? ov_s : ov_u;
            end
        end
    end

    // Control state and response register, synchronously reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!rst_n) begin
            last_q       <= IDW'(NUM_REQ - 1);
            s1_valid_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_ov_q     <= 1'b0;
        end else begin
            last_q       <= last_d;
            s1_valid_q   <= s1_valid_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_ov_q     <= rsp_ov_d;
        end
    end

    // S1 operand payload.
    always_ff @(posedge clk) begin
        // NOTE: payload registers carry no reset; they are only consumed
        // when s1_valid_q is set, which the reset does clear.
        s1_a_q      <= s1_a_d;
        s1_b_q      <= s1_b_d;
        s1_signed_q <= s1_signed_d;
        s1_id_q     <= s1_id_d;
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_ov     = rsp_ov_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed and randomized stimulus for mult_arbiter, checked
// every cycle against a transaction-level model (in-flight queue plus
// round-robin rule) and against hand-computed literal values.
module tb_mult_arbiter;

    localparam int N   = 8;
    localparam int NR  = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*N-1:0]   req_a = '0;
    logic [NR*N-1:0]   req_b = '0;
    logic [NR-1:0]     req_signed = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic [2*N-1:0]    rsp_result;
    logic              rsp_ov;

    always #5 clk = ~clk;

    mult_arbiter #(.N(N), .NUM_REQ(NR), .SATURATE(1'b0), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_ov     (rsp_ov)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product: plain integer arithmetic on the interpreted operands.
    function automatic logic [2*N-1:0] model_prod(input logic [N-1:0] a, input logic [N-1:0] b,
                                                  input logic s);
        int x, y;
        logic [31:0] p;
        x = s ? int'($signed(a)) : int'(a);
        y = s ? int'($signed(b)) : int'(b);
        p = x * y;
        return p[2*N-1:0];
    endfunction

    // Round-robin rule: first valid requester after 'last', wrapping.
    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR])
                return (last + k) % NR;
        end
        return -1;
    endfunction

    // ---------------- Transaction-level model and compare process ----------
    typedef struct {
        int             id;
        logic [2*N-1:0] res;
        bit             vis;   // has spent at least one edge in flight
    } item_t;

    item_t q[$];
    int    grant_log[$];
    int    last_m     = NR - 1;
    bit    zero_state = 1'b1;
    int    wait_cnt[NR];

    initial begin
        forever begin
            int    g;
            bit    exp_v;
            item_t it;
            @(negedge clk);
            #2;
            exp_v = (q.size() > 0) && q[0].vis;
            check("rsp_valid", rsp_valid, exp_v);
            if (exp_v) begin
                zero_state = 1'b0;
                check("rsp_id", rsp_id, q[0].id);
                check("rsp_result", rsp_result, q[0].res);
                check("rsp_ov", rsp_ov, 0);
            end else if (zero_state) begin
                check("rsp_result_after_reset", rsp_result, 0);
                check("rsp_id_after_reset", rsp_id, 0);
                check("rsp_ov_after_reset", rsp_ov, 0);
            end

            g = -1;
            if (rst_n && (q.size() < 2 || rsp_ready))
                g = rr_pick(req_valid, last_m);
            check("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);

            if (!rst_n) begin
                q.delete();
                last_m     = NR - 1;
                zero_state = 1'b1;
                for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
            end else begin
                if (q.size() > 0 && q[0].vis && rsp_ready)
                    void'(q.pop_front());
                if (q.size() > 0)
                    q[0].vis = 1'b1;
                if (g >= 0) begin
                    it.id  = g;
                    it.res = model_prod(req_a[g*N +: N], req_b[g*N +: N], req_signed[g]);
                    it.vis = 1'b0;
                    q.push_back(it);
                    last_m = g;
                    grant_log.push_back(g);
                    check("fair_wait", wait_cnt[g] < NR, 1);
                    for (int i = 0; i < NR; i++)
                        if (i != g && req_valid[i]) wait_cnt[i]++;
                    wait_cnt[g] = 0;
                end
            end
        end
    end

    // ---------------- Requester driver -------------------------------------
    bit            pend[NR];
    logic [N-1:0]  pa[NR];
    logic [N-1:0]  pb[NR];
    logic          ps[NR];
    logic          rst_d = 1'b0;
    logic          rdy_d = 1'b1;
    logic [NR-1:0] acc;

    task automatic arm(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        ps[i]   = s;
    endtask

    // One clock cycle: drive at negedge, then note which requests were taken.
    task automatic step();
        @(negedge clk);
        rst_n     = rst_d;
        rsp_ready = rdy_d;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]        = pend[i];
            req_a[i*N +: N]     = pa[i];
            req_b[i*N +: N]     = pb[i];
            req_signed[i]       = ps[i];
        end
        #3;
        acc = req_valid & req_ready;
        for (int i = 0; i < NR; i++)
            if (acc[i]) pend[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    // Single request with literal expectations for latency and result.
    task automatic single(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic s, input logic [2*N-1:0] exp);
        int ready_cycles, n;
        bit got;
        ready_cycles = 0;
        got = 1'b0;
        arm(i, a, b, s);
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (req_ready[i]) ready_cycles++;
            if (acc[i]) got = 1'b1;
        end
        check("single_accept", got, 1);
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            step();
            n++;
            if (req_ready[i]) ready_cycles++;
            if (rsp_valid) got = 1'b1;
        end
        check("single_latency", n, 2);
        check("single_ready_cycles", ready_cycles, 1);
        check("single_result", rsp_result, exp);
        check("single_id", rsp_id, i);
        check("single_ov", rsp_ov, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start, cnt, acc_cnt;
        logic [2*N-1:0] held_res;
        logic [IDW-1:0] held_id;
        bit found;

        for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; ps[i] = 1'b0;
        end

        // Model pins: hand-computed products.
        check("model_pin_u", model_prod(8'h0C, 8'h0A, 1'b0), 16'h0078);
        check("model_pin_s", model_prod(8'hFF, 8'h02, 1'b1), 16'hFFFE);
        check("model_pin_min", model_prod(8'h80, 8'h80, 1'b1), 16'h4000);

        // Reset.
        rst_d = 1'b0;
        idle(3);
        check("reset_req_ready", req_ready, 0);
        rst_d = 1'b1;
        step();
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_result", rsp_result, 0);

        // Basic function and signedness.
        single(0, 8'h0C, 8'h0A, 1'b0, 16'h0078);
        single(0, 8'hFF, 8'h02, 1'b0, 16'h01FE);
        single(0, 8'hFF, 8'h02, 1'b1, 16'hFFFE);
        single(0, 8'h80, 8'h80, 1'b1, 16'h4000);
        single(3, 8'h7F, 8'h81, 1'b1, 16'hC0FF);

        // Contention: all four held valid; grants rotate 0,1,2,3 with no bubbles.
        grant_log.delete();
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i]) arm(i, 8'(i + 1), 8'h10, 1'b0);
            step();
            if (c >= 2 && rsp_valid) cnt++;
        end
        check("contention_no_bubble", cnt, 6);
        check("contention_grants", grant_log.size() >= 8, 1);
        if (grant_log.size() >= 8)
            for (int k = 0; k < 8; k++)
                check("contention_order", grant_log[k], k % NR);
        for (int c = 0; c < 20 && (pend[0] | pend[1] | pend[2] | pend[3]); c++) step();
        idle(3);

        // Backpressure: two in flight, then stall; output held stable.
        rdy_d = 1'b0;
        acc_cnt = 0;
        held_res = '0;
        held_id = '0;
        for (int c = 0; c < 8; c++) begin
            if (!pend[2]) arm(2, 8'(c + 3), 8'(c + 5), c[0]);
            step();
            if (acc[2]) acc_cnt++;
            if (c == 2) begin
                held_res = rsp_result;
                held_id  = rsp_id;
            end else if (c > 2) begin
                check("bp_hold_result", rsp_result, held_res);
                check("bp_hold_id", rsp_id, held_id);
                check("bp_hold_valid", rsp_valid, 1);
            end
        end
        check("bp_accepts", acc_cnt, 2);
        check("bp_ready_low", req_ready, 0);
        rdy_d = 1'b1;
        acc_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (!pend[2]) arm(2, 8'(c + 20), 8'h03, 1'b1);
            step();
            if (acc[2]) acc_cnt++;
        end
        check("bp_resume", acc_cnt, 4);
        for (int c = 0; c < 10 && pend[2]; c++) step();
        idle(3);

        // Reset mid-flight with S1 and S2 full and last = 1.
        rdy_d = 1'b0;
        acc_cnt = 0;
        for (int c = 0; c < 6 && acc_cnt < 2; c++) begin
            if (!pend[1] && acc_cnt < 2) arm(1, 8'h11, 8'h22, 1'b0);
            step();
            if (acc[1]) acc_cnt++;
        end
        check("midflight_fill", acc_cnt, 2);
        step();
        check("midflight_full", rsp_valid, 1);
        arm(0, 8'h05, 8'h06, 1'b0);
        arm(2, 8'h07, 8'h08, 1'b0);
        rst_d = 1'b0;
        step();
        rst_d = 1'b1;
        rdy_d = 1'b1;
        step();
        check("midflight_rsp_valid", rsp_valid, 0);
        check("midflight_rsp_result", rsp_result, 0);
        check("midflight_first_grant", acc, 4'b0001);
        for (int c = 0; c < 10 && (pend[0] | pend[2]); c++) step();
        idle(4);

        // Late arrival: requester 3 constant, requester 1 joins at cycle 5.
        grant_log.delete();
        start = 0;
        for (int c = 0; c < 14; c++) begin
            if (!pend[3]) arm(3, 8'(c), 8'h09, 1'b1);
            if (c == 5) begin
                arm(1, 8'h42, 8'h03, 1'b0);
                start = grant_log.size();
            end
            step();
        end
        found = 1'b0;
        for (int j = start; j < grant_log.size() && !found; j++)
            if (grant_log[j] == 1) begin
                found = 1'b1;
                check("late_arrival_wait", (j - start) < 2, 1);
            end
        check("late_arrival_granted", found, 1);
        for (int c = 0; c < 10 && (pend[1] | pend[3]); c++) step();
        idle(3);

        // Randomized traffic with random backpressure and occasional reset.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i] && $urandom_range(0, 3) == 0)
                    arm(i, 8'($urandom), 8'($urandom), 1'($urandom));
            rdy_d = ($urandom_range(0, 9) < 7);
            rst_d = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_d = 1'b1;
        rdy_d = 1'b1;
        for (int c = 0; c < 40 && (pend[0] | pend[1] | pend[2] | pend[3]); c++) step();
        check("final_drain", {pend[0], pend[1], pend[2], pend[3]}, 0);
        idle(4);
        check("final_idle", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
